// File: rtl/cu_read_command_responder.sv
// cu_read_command_responder: tags CU read commands, forwards them to memory and routes data/responses back
module cu_read_command_responder #(
    parameter int TAG_WIDTH   = 5,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 512,
    parameter int CU_ID_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   rstn_in,
    input  logic                   enabled_in,
    input  logic                   cmd_in_valid,
    input  logic [ADDR_WIDTH-1:0]  cmd_in_address,
    input  logic [CU_ID_WIDTH-1:0] cmd_in_cu_id,
    output logic                   cmd_in_ready,
    output logic                   mem_cmd_valid,
    output logic [ADDR_WIDTH-1:0]  mem_cmd_address,
    output logic [TAG_WIDTH-1:0]   mem_cmd_tag,
    input  logic                   mem_cmd_ready,
    input  logic                   mem_data_valid,
    input  logic [TAG_WIDTH-1:0]   mem_data_tag,
    input  logic                   mem_data_half,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    input  logic                   mem_resp_valid,
    input  logic [TAG_WIDTH-1:0]   mem_resp_tag,
    input  logic [7:0]             mem_resp_code,
    output logic                   rd_data_0_valid,
    output logic                   rd_data_1_valid,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [CU_ID_WIDTH-1:0] rd_data_cu_id,
    output logic                   rsp_valid,
    output logic [CU_ID_WIDTH-1:0] rsp_cu_id,
    output logic [7:0]             rsp_code,
    output logic [TAG_WIDTH:0]     outstanding,
    output logic                   tags_full,
    output logic                   tags_empty,
    output logic                   error_sticky
);
    localparam int NUM_TAGS = 2 ** TAG_WIDTH;

    logic [NUM_TAGS-1:0]    tag_valid;
    logic [CU_ID_WIDTH-1:0] tag_table [NUM_TAGS];
    logic [TAG_WIDTH-1:0]   alloc_tag;
    logic                   accept;
    logic                   data_hit;
    logic                   resp_hit;

    assign tags_full    = outstanding == (TAG_WIDTH+1)'(NUM_TAGS);
    assign tags_empty   = outstanding == '0;
    assign cmd_in_ready = enabled_in & ~tags_full & (~mem_cmd_valid | mem_cmd_ready);
    assign accept       = cmd_in_valid & cmd_in_ready;
    assign data_hit     = mem_data_valid & tag_valid[mem_data_tag];
    assign resp_hit     = mem_resp_valid & tag_valid[mem_resp_tag];

    // lowest free tag from the registered bitmap, so a tag freed this cycle is not reused yet
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (!tag_valid[i]) alloc_tag = TAG_WIDTH'(i);
    end

    // owner table, written on allocation only; validity lives in tag_valid
    always_ff @(posedge clock)
        if (accept) tag_table[alloc_tag] <= cmd_in_cu_id;

    // tag bitmap and outstanding count; alloc and free never hit the same tag
    always_ff @(posedge clock or negedge rstn_in)
        if (!rstn_in) begin
            tag_valid   <= '0;
            outstanding <= '0;
        end else begin
            if (accept) tag_valid[alloc_tag] <= 1'b1;
            if (resp_hit) tag_valid[mem_resp_tag] <= 1'b0;
            outstanding <= outstanding + (TAG_WIDTH+1)'(accept) - (TAG_WIDTH+1)'(resp_hit);
        end

    // memory command register, held while the memory side stalls
    always_ff @(posedge clock or negedge rstn_in)
        if (!rstn_in) begin
            mem_cmd_valid   <= 1'b0;
            mem_cmd_address <= '0;
            mem_cmd_tag     <= '0;
        end else if (accept) begin
            mem_cmd_valid   <= 1'b1;
            mem_cmd_address <= cmd_in_address;
            mem_cmd_tag     <= alloc_tag;
        end else if (mem_cmd_ready) begin
            mem_cmd_valid   <= 1'b0;
        end

    // data beats to the CU, labelled with the owning cu_id
    always_ff @(posedge clock or negedge rstn_in)
        if (!rstn_in) begin
            rd_data_0_valid <= 1'b0;
            rd_data_1_valid <= 1'b0;
            rd_data         <= '0;
            rd_data_cu_id   <= '0;
        end else begin
            rd_data_0_valid <= data_hit & ~mem_data_half;
            rd_data_1_valid <= data_hit & mem_data_half;
            if (data_hit) begin
                rd_data       <= mem_data;
                rd_data_cu_id <= tag_table[mem_data_tag];
            end
        end

    // completions to the CU
    always_ff @(posedge clock or negedge rstn_in)
        if (!rstn_in) begin
            rsp_valid <= 1'b0;
            rsp_cu_id <= '0;
            rsp_code  <= '0;
        end else begin
            rsp_valid <= resp_hit;
            if (resp_hit) begin
                rsp_cu_id <= tag_table[mem_resp_tag];
                rsp_code  <= mem_resp_code;
            end
        end

    // sticky error on bad codes and on traffic for unallocated tags
    always_ff @(posedge clock or negedge rstn_in)
        if (!rstn_in) error_sticky <= 1'b0;
        else if ((mem_data_valid & ~data_hit) | (mem_resp_valid & ~resp_hit) | (resp_hit & (mem_resp_code != 8'h00)))
            error_sticky <= 1'b1;
endmodule

// File: tb/tb_cu_read_command_responder.sv
// tb_cu_read_command_responder: directed self-checking bench for cu_read_command_responder
module tb_cu_read_command_responder;
    logic         clock = 1'b0;
    logic         rstn_in;
    logic         enabled_in;
    logic         cmd_in_valid;
    logic [63:0]  cmd_in_address;
    logic [7:0]   cmd_in_cu_id;
    logic         cmd_in_ready;
    logic         mem_cmd_valid;
    logic [63:0]  mem_cmd_address;
    logic [4:0]   mem_cmd_tag;
    logic         mem_cmd_ready;
    logic         mem_data_valid;
    logic [4:0]   mem_data_tag;
    logic         mem_data_half;
    logic [511:0] mem_data;
    logic         mem_resp_valid;
    logic [4:0]   mem_resp_tag;
    logic [7:0]   mem_resp_code;
    logic         rd_data_0_valid;
    logic         rd_data_1_valid;
    logic [511:0] rd_data;
    logic [7:0]   rd_data_cu_id;
    logic         rsp_valid;
    logic [7:0]   rsp_cu_id;
    logic [7:0]   rsp_code;
    logic [5:0]   outstanding;
    logic         tags_full;
    logic         tags_empty;
    logic         error_sticky;
    int           tests = 0;
    int           fails = 0;

    cu_read_command_responder dut (
        .clock(clock), .rstn_in(rstn_in), .enabled_in(enabled_in),
        .cmd_in_valid(cmd_in_valid), .cmd_in_address(cmd_in_address), .cmd_in_cu_id(cmd_in_cu_id),
        .cmd_in_ready(cmd_in_ready), .mem_cmd_valid(mem_cmd_valid), .mem_cmd_address(mem_cmd_address),
        .mem_cmd_tag(mem_cmd_tag), .mem_cmd_ready(mem_cmd_ready), .mem_data_valid(mem_data_valid),
        .mem_data_tag(mem_data_tag), .mem_data_half(mem_data_half), .mem_data(mem_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_code(mem_resp_code),
        .rd_data_0_valid(rd_data_0_valid), .rd_data_1_valid(rd_data_1_valid), .rd_data(rd_data),
        .rd_data_cu_id(rd_data_cu_id), .rsp_valid(rsp_valid), .rsp_cu_id(rsp_cu_id), .rsp_code(rsp_code),
        .outstanding(outstanding), .tags_full(tags_full), .tags_empty(tags_empty), .error_sticky(error_sticky)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_in_valid   = 1'b0;
        cmd_in_address = '0;
        cmd_in_cu_id   = '0;
        mem_data_valid = 1'b0;
        mem_data_tag   = '0;
        mem_data_half  = 1'b0;
        mem_data       = '0;
        mem_resp_valid = 1'b0;
        mem_resp_tag   = '0;
        mem_resp_code  = '0;
    endtask

    task automatic cmd(input logic [63:0] a, input logic [7:0] id);
        cmd_in_valid   = 1'b1;
        cmd_in_address = a;
        cmd_in_cu_id   = id;
    endtask

    initial begin
        rstn_in       = 1'b0;
        enabled_in    = 1'b0;
        mem_cmd_ready = 1'b0;
        idle_inputs();
        #12;
        check("rst_mem_cmd_valid", 64'(mem_cmd_valid), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_tags_empty", 64'(tags_empty), 64'd1);
        check("rst_tags_full", 64'(tags_full), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_error", 64'(error_sticky), 64'd0);
        rstn_in       = 1'b1;
        enabled_in    = 1'b1;
        mem_cmd_ready = 1'b1;
        step();

        // single read
        cmd(64'h1000, 8'd3);
        #1 check("single_ready", 64'(cmd_in_ready), 64'd1);
        step();
        cmd_in_valid = 1'b0;
        check("single_cmd_valid", 64'(mem_cmd_valid), 64'd1);
        check("single_cmd_addr", mem_cmd_address, 64'h1000);
        check("single_cmd_tag", 64'(mem_cmd_tag), 64'd0);
        check("single_outstanding", 64'(outstanding), 64'd1);
        check("single_not_empty", 64'(tags_empty), 64'd0);
        mem_data_valid = 1'b1;
        mem_data_tag   = 5'd0;
        mem_data_half  = 1'b0;
        mem_data       = 512'hAAAA;
        step();
        check("beat0_valid0", 64'(rd_data_0_valid), 64'd1);
        check("beat0_valid1", 64'(rd_data_1_valid), 64'd0);
        check("beat0_data", rd_data[63:0], 64'hAAAA);
        check("beat0_cu", 64'(rd_data_cu_id), 64'd3);
        check("cmd_valid_cleared", 64'(mem_cmd_valid), 64'd0);
        mem_data_half = 1'b1;
        mem_data      = 512'hBBBB;
        step();
        check("beat1_valid0", 64'(rd_data_0_valid), 64'd0);
        check("beat1_valid1", 64'(rd_data_1_valid), 64'd1);
        check("beat1_data", rd_data[63:0], 64'hBBBB);
        mem_data_valid = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'd0;
        mem_resp_code  = 8'h00;
        step();
        mem_resp_valid = 1'b0;
        check("resp_valid", 64'(rsp_valid), 64'd1);
        check("resp_cu", 64'(rsp_cu_id), 64'd3);
        check("resp_code", 64'(rsp_code), 64'd0);
        check("resp_outstanding", 64'(outstanding), 64'd0);
        check("resp_empty", 64'(tags_empty), 64'd1);
        check("resp_beat_done", 64'(rd_data_1_valid), 64'd0);
        check("resp_no_error", 64'(error_sticky), 64'd0);

        // fill all 32 tags
        for (int i = 0; i < 32; i++) begin
            cmd(64'(i * 64), 8'(i));
            step();
            check("fill_tag", 64'(mem_cmd_tag), 64'(i));
        end
        check("fill_full", 64'(tags_full), 64'd1);
        check("fill_outstanding", 64'(outstanding), 64'd32);
        check("fill_ready", 64'(cmd_in_ready), 64'd0);
        cmd_in_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'd7;
        step();
        mem_resp_valid = 1'b0;
        check("free7_cu", 64'(rsp_cu_id), 64'd7);
        check("free7_outstanding", 64'(outstanding), 64'd31);
        cmd(64'h7700, 8'h55);
        step();
        cmd_in_valid = 1'b0;
        check("realloc_tag", 64'(mem_cmd_tag), 64'd7);
        check("realloc_full", 64'(tags_full), 64'd1);
        mem_data_valid = 1'b1;
        mem_data_tag   = 5'd7;
        mem_data_half  = 1'b0;
        mem_data       = 512'h77;
        step();
        mem_data_valid = 1'b0;
        check("realloc_beat_cu", 64'(rd_data_cu_id), 64'h55);
        for (int i = 0; i < 32; i++) begin
            mem_resp_valid = 1'b1;
            mem_resp_tag   = 5'(i);
            step();
            check("drain_cu", 64'(rsp_cu_id), (i == 7) ? 64'h55 : 64'(i));
        end
        mem_resp_valid = 1'b0;
        check("drain_outstanding", 64'(outstanding), 64'd0);
        check("drain_no_error", 64'(error_sticky), 64'd0);

        // backpressure
        mem_cmd_ready = 1'b0;
        cmd(64'h2000, 8'd9);
        step();
        cmd(64'h3000, 8'd10);
        for (int i = 0; i < 5; i++) begin
            check("bp_addr", mem_cmd_address, 64'h2000);
            check("bp_ready", 64'(cmd_in_ready), 64'd0);
            step();
        end
        check("bp_tag", 64'(mem_cmd_tag), 64'd0);
        check("bp_outstanding", 64'(outstanding), 64'd1);
        mem_cmd_ready = 1'b1;
        #1 check("bp_release_ready", 64'(cmd_in_ready), 64'd1);
        step();
        cmd_in_valid = 1'b0;
        check("bp_next_addr", mem_cmd_address, 64'h3000);
        check("bp_next_tag", 64'(mem_cmd_tag), 64'd1);
        check("bp_next_outstanding", 64'(outstanding), 64'd2);
        step();
        check("bp_idle", 64'(mem_cmd_valid), 64'd0);

        // simultaneous allocate and free
        cmd(64'h4000, 8'h12);
        step();
        cmd(64'h4040, 8'h13);
        step();
        check("sim_pre_outstanding", 64'(outstanding), 64'd4);
        cmd(64'h4080, 8'h20);
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'd2;
        step();
        mem_resp_valid = 1'b0;
        check("sim_outstanding", 64'(outstanding), 64'd4);
        check("sim_tag", 64'(mem_cmd_tag), 64'd4);
        check("sim_rsp_cu", 64'(rsp_cu_id), 64'h12);
        cmd(64'h40c0, 8'h21);
        step();
        cmd_in_valid = 1'b0;
        check("sim_reuse_tag", 64'(mem_cmd_tag), 64'd2);
        check("sim_outstanding5", 64'(outstanding), 64'd5);
        mem_data_valid = 1'b1;
        mem_data_tag   = 5'd3;
        mem_data_half  = 1'b0;
        mem_data       = 512'h3333;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'd3;
        step();
        mem_data_valid = 1'b0;
        mem_resp_valid = 1'b0;
        check("same_tag_beat", 64'(rd_data_0_valid), 64'd1);
        check("same_tag_beat_cu", 64'(rd_data_cu_id), 64'h13);
        check("same_tag_rsp", 64'(rsp_valid), 64'd1);

        // errors
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'd0;
        mem_resp_code  = 8'h05;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_code  = 8'h00;
        check("err_rsp_valid", 64'(rsp_valid), 64'd1);
        check("err_rsp_code", 64'(rsp_code), 64'h05);
        check("err_rsp_cu", 64'(rsp_cu_id), 64'd9);
        check("err_sticky", 64'(error_sticky), 64'd1);
        check("pre_reset_outstanding", 64'(outstanding), 64'd3);

        // reset mid-flight
        rstn_in = 1'b0;
        #1;
        check("mid_rst_outstanding", 64'(outstanding), 64'd0);
        check("mid_rst_empty", 64'(tags_empty), 64'd1);
        check("mid_rst_error", 64'(error_sticky), 64'd0);
        check("mid_rst_cmd_valid", 64'(mem_cmd_valid), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        #2 rstn_in = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_tag   = 5'd9;
        mem_data_valid = 1'b1;
        mem_data_tag   = 5'd1;
        step();
        mem_resp_valid = 1'b0;
        mem_data_valid = 1'b0;
        check("free_tag_no_rsp", 64'(rsp_valid), 64'd0);
        check("free_tag_no_beat", 64'(rd_data_0_valid), 64'd0);
        check("free_tag_error", 64'(error_sticky), 64'd1);
        cmd(64'h5000, 8'd4);
        step();
        cmd_in_valid = 1'b0;
        check("post_rst_tag", 64'(mem_cmd_tag), 64'd0);
        check("post_rst_outstanding", 64'(outstanding), 64'd1);

        // enable low blocks commands, data still drains
        enabled_in = 1'b0;
        cmd(64'h6000, 8'd6);
        mem_data_valid = 1'b1;
        mem_data_tag   = 5'd0;
        mem_data_half  = 1'b1;
        mem_data       = 512'h6666;
        #1 check("dis_ready", 64'(cmd_in_ready), 64'd0);
        step();
        idle_inputs();
        check("dis_beat", 64'(rd_data_1_valid), 64'd1);
        check("dis_beat_cu", 64'(rd_data_cu_id), 64'd4);
        check("dis_outstanding", 64'(outstanding), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cu_read_command_responder.md
Name: cu_read_command_responder

Overview:
- Memory-side counterpart of the compute-unit read path.
- Accepts read commands from the CU cluster and allocates a hardware tag to each.
- Issues each tagged command toward the PSL-facing command interface.
- Returns incoming half-line data beats and completion responses to the CU side, labelled with the originating cu_id.

Parameters:
TAG_WIDTH, 5, tag index width; NUM_TAGS = 2**TAG_WIDTH outstanding reads
ADDR_WIDTH, 64, command address width
DATA_WIDTH, 512, width of one half cache line (one of two beats per 128B line)
CU_ID_WIDTH, 8, compute-unit identifier width

Ports:
clock  in  1  clock
rstn_in  in  1  reset
enabled_in  in  1  global enable; 0 blocks command acceptance only
cmd_in_valid  in  1  CU read command valid
cmd_in_address  in  ADDR_WIDTH  read address
cmd_in_cu_id  in  CU_ID_WIDTH  requesting CU
cmd_in_ready  out  1  command accepted when valid&ready
mem_cmd_valid  out  1  tagged command to memory side
mem_cmd_address  out  ADDR_WIDTH  forwarded address
mem_cmd_tag  out  TAG_WIDTH  allocated tag
mem_cmd_ready  in  1  memory side accepts when valid&ready
mem_data_valid  in  1  data beat valid
mem_data_tag  in  TAG_WIDTH  beat tag
mem_data_half  in  1  0 = lower half, 1 = upper half
mem_data  in  DATA_WIDTH  beat payload
mem_resp_valid  in  1  completion valid
mem_resp_tag  in  TAG_WIDTH  completion tag
mem_resp_code  in  8  0x00 = done, otherwise error
rd_data_0_valid  out  1  lower-half beat to CU
rd_data_1_valid  out  1  upper-half beat to CU
rd_data  out  DATA_WIDTH  beat payload
rd_data_cu_id  out  CU_ID_WIDTH  owner of beat
rsp_valid  out  1  completion to CU
rsp_cu_id  out  CU_ID_WIDTH  owner of completion
rsp_code  out  8  forwarded code
outstanding  out  TAG_WIDTH+1  allocated tag count
tags_full  out  1  outstanding == NUM_TAGS
tags_empty  out  1  outstanding == 0
error_sticky  out  1  any nonzero resp code, or protocol violation

Behaviour:
Reset (rstn_in low, asynchronous):
- All outputs 0, except tags_empty = 1.
- Tag-valid bitmap cleared.
- Output register emptied.
- Reset mid-operation discards all in-flight tags; late responses after reset count as protocol errors.

Tag allocation:
- Free-list bitmap; the lowest-index free tag is chosen by priority encoder.
- tag_table[tag] stores cu_id.

Command path:
- cmd_in_ready = enabled_in & ~tags_full & (~mem_cmd_valid | mem_cmd_ready). Combinational from registered state plus mem_cmd_ready.
- On accept: tag marked valid, cu_id written; mem_cmd_valid/address/tag registered next cycle (1-cycle latency).
- mem_cmd_* held stable while mem_cmd_valid & ~mem_cmd_ready.
- mem_cmd_valid clears after handshake if no new accept.
- Back-to-back accepts sustain 1 command/cycle when mem_cmd_ready stays high.

Data path:
- Registered, 1-cycle latency.
- rd_data_N_valid (N = mem_data_half) pulses 1 cycle; rd_data = mem_data; rd_data_cu_id = tag_table[mem_data_tag].
- No backpressure.
- Beat on an unallocated tag: dropped, error_sticky set.

Response path:
- Registered, 1-cycle latency.
- rsp_valid pulses; rsp_cu_id = tag_table[tag]; rsp_code = mem_resp_code.
- Tag freed at the same edge.
- Nonzero code sets error_sticky, but the response is still forwarded.
- Response on an unallocated tag: dropped, error_sticky set.

Simultaneous events:
- Allocate and free in the same cycle leaves outstanding unchanged.
- A freed tag is not re-allocatable until the following cycle (the encoder uses the registered bitmap).
- A data beat and a response for the same tag in the same cycle: the beat is forwarded using the still-valid entry.

Counter and flags:
- outstanding saturates logically at NUM_TAGS; it can never exceed it because ready is gated.
- tags_full/tags_empty derive from the registered count.

Enable:
- enabled_in low blocks new commands only.
- In-flight data and responses continue to drain.

Test Plan:
- Single read: cmd address 0x1000, cu_id 3 -> mem_cmd tag 0 one cycle later. Beats half 0 and half 1 on tag 0 -> rd_data_0_valid then rd_data_1_valid with cu_id 3. resp code 0 -> rsp_valid with cu_id 3, outstanding 1 -> 0, tags_empty 1.
- Fill: 32 commands with mem_cmd_ready = 1 -> tags 0..31 in order, tags_full 1, cmd_in_ready 0. Response on tag 7 -> next accept gets tag 7.
- Backpressure: mem_cmd_ready = 0 for 5 cycles with a command pending -> mem_cmd_* stable, cmd_in_ready 0. Release -> handshake, then the next command flows.
- Simultaneous: accept a command and receive a response for tag 2 in the same cycle with outstanding 4 -> outstanding stays 4, tag 2 not re-issued that cycle.
- Errors: resp code 0x05 on a valid tag -> forwarded, error_sticky 1. Response on a free tag 9 -> no rsp_valid, error_sticky 1.
- Reset mid-flight: 3 outstanding, assert rstn_in -> all outputs 0, tags_empty 1. After release, the first command gets tag 0.
